uart_tx: RTL

8N1 UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. Accepts bytes over a valid/ready handshake from the host-side command/response logic. Serialises them onto the `tx` line at `BAUD_RATE`. It is the transmit half of the host link and is bit-compatible with the in-tree `uart_rx` at the same `CLOCK_FREQ`/`BAUD_RATE`.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 70 +++++++
 rtl/uart_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, 8N1 frame constants and the bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; FIFO_DEPTH must be a power of two.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [UART_DATA_BITS-1:0]     push_data,
    input  logic                          pop,
    output logic [UART_DATA_BITS-1:0]     pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [UART_DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW:0]               count_q, count_d;
    logic                      do_push, do_pop;

    assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input and registered serial output.
// Define UART_TX_FIFO_EN to queue up to FIFO_DEPTH bytes and send queued frames back-to-back.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam logic [15:0] LAST_COUNT   = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);

    uart_state_t state_q, state_d;
    logic [15:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;

    logic        byte_avail;
    logic        queued;
    logic [7:0]  byte_next;

`ifdef UART_TX_FIFO_EN
    logic                         fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    // Pop happens exactly where the FSM loads a byte; the FIFO ignores pops while empty.
    assign fifo_pop = (state_q == IDLE) ||
                      ((state_q == STOP) && (clk_count_q == LAST_COUNT));

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid && !fifo_full),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (byte_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_ready   = !fifo_full;
    assign byte_avail = !fifo_empty;
    assign queued     = (fifo_count != '0);
`else
    assign tx_ready   = (state_q == IDLE);
    assign byte_avail = tx_valid;
    assign queued     = 1'b0;
    assign byte_next  = tx_data;
`endif

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        case (state_q)
            IDLE: begin
                if (byte_avail) begin
                    shift_d     = byte_next;
                    clk_count_d = '0;
                    state_d     = START;
                end
            end
            START: begin
                if (clk_count_q == LAST_COUNT) begin
                    clk_count_d = '0;
                    bit_index_d = '0;
                    state_d     = DATA;
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            DATA: begin
                if (clk_count_q == LAST_COUNT) begin
                    clk_count_d = '0;
                    if (bit_index_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            STOP: begin
                if (clk_count_q == LAST_COUNT) begin
                    clk_count_d = '0;
                    if (queued) begin
                        shift_d = byte_next;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level and busy flag follow the current state, one register stage behind.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[bit_index_q];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE) || queued;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule
